// File: rtl/xpb_table_gen_if.sv
// -----------------------------------------------------------------------------
// xpb_table_gen_if
// Bundles the request and table-write signals of the XPB table generator.
//   master : requester side  - drives start/modulus/base, observes the rest
//   slave  : generator side  - observes start/modulus/base, drives the rest
// Signals:
//   start    1         one-cycle generation request
//   modulus  WIDTH     modulus N
//   base     WIDTH     base B (B < N)
//   wr_en    1         table write strobe
//   wr_addr  IDX_BITS  table index j
//   wr_data  WIDTH     entry value j*B mod N
//   busy     1         generation in progress
//   done     1         one-cycle completion pulse
// -----------------------------------------------------------------------------
interface xpb_table_gen_if #(
   parameter int WIDTH    = 1024,
   parameter int IDX_BITS = 5
) ();
   logic                start;
   logic [WIDTH-1:0]    modulus;
   logic [WIDTH-1:0]    base;
   logic                wr_en;
   logic [IDX_BITS-1:0] wr_addr;
   logic [WIDTH-1:0]    wr_data;
   logic                busy;
   logic                done;

   modport master (
      output start, modulus, base,
      input  wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      input  start, modulus, base,
      output wr_en, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/xpb_table_gen.sv
// -----------------------------------------------------------------------------
// xpb_table_gen
// Computes the XPB lookup table entries j*B mod N for j = 0 .. 2^IDX_BITS-1 and
// streams them out over a simple RAM write port. Each new entry is the previous
// one plus B, reduced once against N. The addition and the trial subtraction
// run one CHUNK-bit slice per cycle, so no full-width carry chain is built.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   xpb_table_gen_if.slave: start/modulus/base in,
//         wr_en/wr_addr/wr_data/busy/done out (all registered)
// -----------------------------------------------------------------------------
module xpb_table_gen #(
   parameter int WIDTH    = 1024,
   parameter int CHUNK    = 64,
   parameter int IDX_BITS = 5
) (
   input  logic            clk,
   input  logic            rst,
   xpb_table_gen_if.slave  bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0]       C_LAST = CW'(NCHUNK - 1);
   localparam logic [IDX_BITS-1:0] J_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_ADD,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state_q,   state_d;
   logic [WIDTH-1:0]    n_q,       n_d;       // latched modulus
   logic [WIDTH-1:0]    b_q,       b_d;       // latched base
   logic [WIDTH-1:0]    a_q,       a_d;       // accumulator: current entry
   logic [WIDTH-1:0]    s_q,       s_d;       // shadow: A + B
   logic [WIDTH-1:0]    diff_q,    diff_d;    // shadow: A + B - N
   logic [CW-1:0]       c_q,       c_d;       // slice counter
   logic [IDX_BITS-1:0] j_q,       j_d;       // index of the next entry
   logic                carry_q,   carry_d;
   logic                borrow_q,  borrow_d;
   logic                wr_en_q,   wr_en_d;
   logic [IDX_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;

   // Slice datapath
   int                  lsb;
   logic [CHUNK-1:0]    a_sl, b_sl, n_sl;
   logic [CHUNK:0]      sum_sl, dif_sl;
   logic [WIDTH-1:0]    result;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d   = state_q;
      n_d       = n_q;
      b_d       = b_q;
      a_d       = a_q;
      s_d       = s_q;
      diff_d    = diff_q;
      c_d       = c_q;
      j_d       = j_q;
      carry_d   = carry_q;
      borrow_d  = borrow_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      lsb    = int'(c_q) * CHUNK;
      a_sl   = a_q[lsb +: CHUNK];
      b_sl   = b_q[lsb +: CHUNK];
      n_sl   = n_q[lsb +: CHUNK];
      sum_sl = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      // Top bit of the wrapped difference is the borrow out of this slice.
      dif_sl = {1'b0, sum_sl[CHUNK-1:0]} - {1'b0, n_sl} - {{CHUNK{1'b0}}, borrow_q};
      // A carry out of the full sum means it exceeds 2^WIDTH > N; no borrow
      // means the WIDTH-bit sum is already >= N. Either way subtract N once.
      result = (carry_q || !borrow_q) ? diff_q : s_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               n_d     = bus.modulus;
               b_d     = bus.base;
               state_d = S_INIT;
            end
         end

         S_INIT: begin
            a_d       = '0;
            c_d       = '0;
            carry_d   = 1'b0;
            borrow_d  = 1'b0;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = '0;
            busy_d    = 1'b1;
            j_d       = IDX_BITS'(1);
            state_d   = S_ADD;
         end

         S_ADD: begin
            s_d[lsb +: CHUNK]    = sum_sl[CHUNK-1:0];
            diff_d[lsb +: CHUNK] = dif_sl[CHUNK-1:0];
            carry_d              = sum_sl[CHUNK];
            borrow_d             = dif_sl[CHUNK];
            if (c_q == C_LAST) begin
               c_d     = '0;
               state_d = S_WRITE;
            end else begin
               c_d = c_q + 1'b1;
            end
         end

         S_WRITE: begin
            a_d       = result;
            wr_data_d = result;
            wr_addr_d = j_q;
            wr_en_d   = 1'b1;
            j_d       = j_q + 1'b1;
            carry_d   = 1'b0;
            borrow_d  = 1'b0;
            // Stop after the last index so entry 0 is never rewritten.
            state_d   = (j_q == J_LAST) ? S_DONE : S_ADD;
         end

         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples its _d value from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         b_q       <= '0;
         a_q       <= '0;
         s_q       <= '0;
         diff_q    <= '0;
         c_q       <= '0;
         j_q       <= '0;
         carry_q   <= 1'b0;
         borrow_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         b_q       <= b_d;
         a_q       <= a_d;
         s_q       <= s_d;
         diff_q    <= diff_d;
         c_q       <= c_d;
         j_q       <= j_d;
         carry_q   <= carry_d;
         borrow_q  <= borrow_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// -----------------------------------------------------------------------------
// tb_xpb_table_gen
// Two instances: a narrow one (WIDTH=16, CHUNK=4) for the directed tables and
// a default-width one (WIDTH=1024, CHUNK=64) checked against a modular-addition
// reference. Expected writes (index, value, cycle) are queued when a run is
// started and popped by a per-instance monitor when wr_en is seen.
// Cycle numbering: cyc counts rising edges; the edge that samples start is t0,
// and "cycle k" is the period following edge t0+k.
// -----------------------------------------------------------------------------
module tb_xpb_table_gen;

   typedef struct {
      int            addr;
      logic [1023:0] data;
      int            cyc;
   } exp_t;

   localparam int ENTRIES = 32;

   logic clk;
   logic rst;
   int   cyc;
   int   compared;
   int   mismatched;
   int   wr_count_s;
   int   wr_count_l;
   exp_t q_s[$];
   exp_t q_l[$];

   xpb_table_gen_if #(.WIDTH(16),   .IDX_BITS(5)) sif ();
   xpb_table_gen_if #(.WIDTH(1024), .IDX_BITS(5)) lif ();

   xpb_table_gen #(.WIDTH(16), .CHUNK(4), .IDX_BITS(5)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   xpb_table_gen #(.WIDTH(1024), .CHUNK(64), .IDX_BITS(5)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (lif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Narrow-instance monitor
   always @(negedge clk) begin : mon_s
      exp_t e;
      if (sif.wr_en === 1'b1) begin
         wr_count_s++;
         compared++;
         if (q_s.size() == 0) begin
            mismatched++;
            $display("FAIL small_unexpected_write: got addr=%0d data=%h at cycle %0d, required no write",
                     sif.wr_addr, sif.wr_data, cyc);
         end else begin
            e = q_s.pop_front();
            if (sif.wr_addr !== e.addr[4:0] || sif.wr_data !== e.data[15:0] || cyc !== e.cyc) begin
               mismatched++;
               $display("FAIL small_entry: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                        sif.wr_addr, sif.wr_data, cyc, e.addr, e.data[15:0], e.cyc);
            end
         end
      end
   end

   // Default-width-instance monitor
   always @(negedge clk) begin : mon_l
      exp_t e;
      if (lif.wr_en === 1'b1) begin
         wr_count_l++;
         compared++;
         if (q_l.size() == 0) begin
            mismatched++;
            $display("FAIL large_unexpected_write: got addr=%0d at cycle %0d, required no write",
                     lif.wr_addr, cyc);
         end else begin
            e = q_l.pop_front();
            if (lif.wr_addr !== e.addr[4:0] || lif.wr_data !== e.data || cyc !== e.cyc) begin
               mismatched++;
               $display("FAIL large_entry: got addr=%0d cycle=%0d low=%h, required addr=%0d cycle=%0d low=%h",
                        lif.wr_addr, cyc, lif.wr_data[63:0], e.addr, e.cyc, e.data[63:0]);
            end
         end
      end
   end

   // Starts the narrow instance and queues the expected table; returns t0.
   task automatic start_small(input logic [15:0] n, input logic [15:0] b, output int t0);
      exp_t e;
      @(negedge clk);
      sif.start   = 1'b1;
      sif.modulus = n;
      sif.base    = b;
      wr_count_s  = 0;
      @(posedge clk);
      #1;
      t0 = cyc;
      for (int j = 0; j < ENTRIES; j++) begin
         e.addr = j;
         e.data = '0;
         e.data[15:0] = 16'((longint'(j) * longint'(b)) % longint'(n));
         e.cyc  = t0 + 1 + j * 5;
         q_s.push_back(e);
      end
      @(negedge clk);
      sif.start = 1'b0;
   endtask

   // Waits (bounded) for the narrow done pulse and checks completion timing.
   task automatic finish_small(input string name, input int t0);
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (sif.done === 1'b1) seen = 1;
      end
      compared++;
      if (!seen) begin
         mismatched++;
         $display("FAIL %s_done_timeout: got no done pulse, required one at cycle %0d", name, t0 + 157);
         q_s.delete();
      end else begin
         if (cyc !== t0 + 157 || sif.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_done: got cycle=%0d busy=%b, required cycle=%0d busy=0",
                     name, cyc, sif.busy, t0 + 157);
         end
         @(negedge clk);
         compared++;
         if (sif.done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_done_pulse: got done=%b one cycle later, required 0", name, sif.done);
         end
      end
      compared++;
      if (wr_count_s !== ENTRIES || q_s.size() !== 0) begin
         mismatched++;
         $display("FAIL %s_write_count: got %0d writes (%0d still expected), required %0d",
                  name, wr_count_s, q_s.size(), ENTRIES);
         q_s.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      compared++;
      if ({sif.wr_en, sif.busy, sif.done} !== 3'b000 || sif.wr_addr !== 5'd0 || sif.wr_data !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_small: got en=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                  sif.wr_en, sif.busy, sif.done, sif.wr_addr, sif.wr_data);
      end
      compared++;
      if ({lif.wr_en, lif.busy, lif.done} !== 3'b000 || lif.wr_addr !== 5'd0 || lif.wr_data !== '0) begin
         mismatched++;
         $display("FAIL reset_large: got en=%b busy=%b done=%b addr=%0d, required all 0",
                  lif.wr_en, lif.busy, lif.done, lif.wr_addr);
      end
   endtask

   task automatic test_table(input string name, input logic [15:0] n, input logic [15:0] b);
      int t0;
      start_small(n, b, t0);
      // busy must be up in cycle 1
      while (cyc < t0 + 1) @(negedge clk);
      compared++;
      if (sif.busy !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_busy: got busy=%b in cycle 1, required 1", name, sif.busy);
      end
      finish_small(name, t0);
   endtask

   task automatic test_start_while_busy();
      int t0;
      start_small(16'hFFF1, 16'h0010, t0);
      while (cyc < t0 + 39) @(negedge clk);
      sif.start = 1'b1;
      sif.base  = 16'h0001;
      @(negedge clk);
      sif.start = 1'b0;
      sif.base  = 16'h0010;
      finish_small("start_while_busy", t0);
   endtask

   task automatic test_reset_mid_run();
      int t0;
      start_small(16'hFFF1, 16'h0010, t0);
      while (cyc < t0 + 60) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q_s.delete();   // remaining entries must never be written
      @(negedge clk);
      compared++;
      if ({sif.wr_en, sif.busy, sif.done} !== 3'b000) begin
         mismatched++;
         $display("FAIL mid_reset_outputs: got en=%b busy=%b done=%b, required 0 0 0",
                  sif.wr_en, sif.busy, sif.done);
      end
      // Any write in this window is flagged by the monitor (queue is empty).
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         compared++;
         if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_idle: got busy=%b done=%b at cycle %0d, required 0 0",
                     sif.busy, sif.done, cyc);
         end
      end
      test_table("after_reset", 16'hFFF1, 16'h0010);
   endtask

   task automatic test_default_width();
      logic [1023:0] n;
      logic [1024:0] nn, r, acc;
      exp_t e;
      int   t0;
      bit   seen = 0;
      for (int i = 0; i < 32; i++) n[i*32 +: 32] = $urandom;
      n[1023] = 1'b1;
      n[0]    = 1'b1;
      nn = {1'b0, n};
      // B = 2^1024 mod N by repeated modular doubling
      r = 1025'd1;
      for (int i = 0; i < 1024; i++) begin
         r = r << 1;
         if (r >= nn) r = r - nn;
      end
      @(negedge clk);
      lif.start   = 1'b1;
      lif.modulus = n;
      lif.base    = r[1023:0];
      wr_count_l  = 0;
      @(posedge clk);
      #1;
      t0  = cyc;
      acc = '0;
      for (int j = 0; j < ENTRIES; j++) begin
         e.addr = j;
         e.data = acc[1023:0];
         e.cyc  = t0 + 1 + j * 17;
         q_l.push_back(e);
         acc = acc + r;
         if (acc >= nn) acc = acc - nn;
      end
      @(negedge clk);
      lif.start = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         @(negedge clk);
         if (lif.done === 1'b1) seen = 1;
      end
      compared++;
      if (!seen || cyc !== t0 + 529) begin
         mismatched++;
         $display("FAIL large_done: got seen=%0d cycle=%0d, required done at cycle %0d",
                  seen, cyc, t0 + 529);
      end
      compared++;
      if (wr_count_l !== ENTRIES || q_l.size() !== 0) begin
         mismatched++;
         $display("FAIL large_write_count: got %0d writes (%0d still expected), required %0d",
                  wr_count_l, q_l.size(), ENTRIES);
         q_l.delete();
      end
   endtask

   initial begin
      cyc         = 0;
      compared    = 0;
      mismatched  = 0;
      wr_count_s  = 0;
      wr_count_l  = 0;
      rst         = 1'b1;
      sif.start   = 1'b0;
      sif.modulus = '0;
      sif.base    = '0;
      lif.start   = 1'b0;
      lif.modulus = '0;
      lif.base    = '0;

      test_reset();
      test_table("linear",        16'hFFF1, 16'h0010);
      test_table("small_modulus", 16'h000B, 16'h0007);
      test_table("carry_out",     16'hFFF1, 16'hFFF0);
      test_table("zero_base",     16'hFFF1, 16'h0000);
      test_reset_mid_run();
      test_start_while_busy();
      test_default_width();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
